// File: rtl/coprocessor_pkg.sv
`default_nettype none
// ============================================================================
// coprocessor_pkg
// Shared constants, loader state encoding and size-legality helper for the
// matrix coprocessor datapath (loader and ALU modules).
// Revision: 1.0
// ============================================================================
package coprocessor_pkg;

    localparam int DIM      = 5;
    localparam int ELEM_W   = 8;
    localparam int FLAT_W   = DIM * DIM * ELEM_W;
    localparam int SIZE_W   = 3;
    localparam int SIZE_MIN = 2;
    localparam int SIZE_MAX = DIM;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } loader_state_e;

    // Legal active dimension is SIZE_MIN..max_dim (max_dim is the instance's DIM).
    function automatic logic size_is_legal(input logic [SIZE_W-1:0] sz, input int max_dim);
        return (int'(sz) >= SIZE_MIN) && (int'(sz) <= max_dim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_index_counter.sv
`default_nettype none
// ============================================================================
// matrix_index_counter
// Row-major (row, col) position counter that wraps at the active size.
// Revision: 1.0
// ============================================================================
module matrix_index_counter
    import coprocessor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [SIZE_W-1:0] size,
    output logic [SIZE_W-1:0] row,
    output logic [SIZE_W-1:0] col,
    output logic              last
);

    logic [SIZE_W-1:0] row_q, row_d;
    logic [SIZE_W-1:0] col_q, col_d;
    logic [SIZE_W-1:0] size_m1;
    logic              col_end;
    logic              row_end;

    assign size_m1 = size - SIZE_W'(1);
    assign col_end = (col_q == size_m1);
    assign row_end = (row_q == size_m1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + SIZE_W'(1);
            end else begin
                col_d = col_q + SIZE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = col_end && row_end;

endmodule
`default_nettype wire

// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// matrix_operand_loader
// Assembles one or two DIMxDIM operands from a row-major byte stream into
// zero-padded flat buses and hands them to the ALU with valid/ack.
// Optional feature macro: MATRIX_LOADER_TIMEOUT_EN (idle-beat timeout).
// Revision: 1.0
// ============================================================================
module matrix_operand_loader
    import coprocessor_pkg::*;
#(
    parameter int DIM            = coprocessor_pkg::DIM,
    parameter int ELEM_W         = coprocessor_pkg::ELEM_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SIZE_W-1:0]         size,
    input  logic                      two_op,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DIM*DIM*ELEM_W-1:0] A_flat,
    output logic [DIM*DIM*ELEM_W-1:0] B_flat,
    output logic                      mats_valid,
    input  logic                      mats_ack,
    output logic                      busy,
    output logic                      err
);

    localparam int FLAT_BITS = DIM * DIM * ELEM_W;
    localparam int OFF_W     = $clog2(FLAT_BITS);

    loader_state_e          state_q, state_d;
    logic [SIZE_W-1:0]      size_q, size_d;
    logic                   two_op_q, two_op_d;
    logic [FLAT_BITS-1:0]   a_flat_q, a_flat_d;
    logic [FLAT_BITS-1:0]   b_flat_q, b_flat_d;
    logic                   in_ready_q, in_ready_d;
    logic                   mats_valid_q, mats_valid_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic                   beat;
    logic                   idx_clear;
    logic [SIZE_W-1:0]      row;
    logic [SIZE_W-1:0]      col;
    logic                   last;
    logic [OFF_W-1:0]       wr_off;

`ifdef MATRIX_LOADER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
`endif

    matrix_index_counter u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (idx_clear),
        .advance (beat),
        .size    (size_q),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // in_ready_q is only ever set in the load states, so it alone qualifies a beat.
    assign beat   = in_valid && in_ready_q;
    assign wr_off = OFF_W'((int'(row) * DIM + int'(col)) * ELEM_W);

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        two_op_d  = two_op_q;
        a_flat_d  = a_flat_q;
        b_flat_d  = b_flat_q;
        err_d     = 1'b0;
        idx_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_is_legal(size, DIM)) begin
                        size_d    = size;
                        two_op_d  = two_op;
                        a_flat_d  = '0;
                        b_flat_d  = '0;
                        idx_clear = 1'b1;
                        state_d   = LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_A: begin
                if (beat) begin
                    a_flat_d[wr_off +: ELEM_W] = in_data;
                    if (last) begin
                        state_d = two_op_q ? LOAD_B : DONE;
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    b_flat_d[wr_off +: ELEM_W] = in_data;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (mats_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MATRIX_LOADER_TIMEOUT_EN
        idle_cnt_d = '0;
        if ((state_q == LOAD_A || state_q == LOAD_B) && !beat) begin
            if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_d     = 1'b1;
                a_flat_d  = '0;
                b_flat_d  = '0;
                idx_clear = 1'b1;
                state_d   = IDLE;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
`endif

        // Status outputs are registered off the next state so they align with it.
        in_ready_d   = (state_d == LOAD_A) || (state_d == LOAD_B);
        mats_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            size_q       <= '0;
            two_op_q     <= 1'b0;
            a_flat_q     <= '0;
            b_flat_q     <= '0;
            in_ready_q   <= 1'b0;
            mats_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            two_op_q     <= two_op_d;
            a_flat_q     <= a_flat_d;
            b_flat_q     <= b_flat_d;
            in_ready_q   <= in_ready_d;
            mats_valid_q <= mats_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef MATRIX_LOADER_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign A_flat     = a_flat_q;
    assign B_flat     = b_flat_q;
    assign mats_valid = mats_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_matrix_operand_loader
// Directed plus randomized bench with a flat-array reference model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_matrix_operand_loader;

    localparam int TDIM = 5;
    localparam int TEW  = 8;
    localparam int TFW  = TDIM * TDIM * TEW;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            start    = 1'b0;
    logic [2:0]      size     = 3'd0;
    logic            two_op   = 1'b0;
    logic [TEW-1:0]  in_data  = '0;
    logic            in_valid = 1'b0;
    logic            mats_ack = 1'b0;
    logic            in_ready;
    logic            mats_valid;
    logic            busy;
    logic            err;
    logic [TFW-1:0]  A_flat;
    logic [TFW-1:0]  B_flat;

    logic [TFW-1:0]  exp_a = '0;
    logic [TFW-1:0]  exp_b = '0;
    int              n_tests  = 0;
    int              n_fail   = 0;
    int              next_val = 0;
    int              val_step = 1;

    always #5 clk = ~clk;

    matrix_operand_loader #(
        .DIM            (TDIM),
        .ELEM_W         (TEW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .size       (size),
        .two_op     (two_op),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A_flat     (A_flat),
        .B_flat     (B_flat),
        .mats_valid (mats_valid),
        .mats_ack   (mats_ack),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [TFW-1:0] obs, input logic [TFW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_A"}, A_flat, '0);
        chk({tag, "_B"}, B_flat, '0);
        chk({tag, "_ready"}, TFW'(in_ready), '0);
        chk({tag, "_valid"}, TFW'(mats_valid), '0);
        chk({tag, "_busy"}, TFW'(busy), '0);
        chk({tag, "_err"}, TFW'(err), '0);
    endtask

    task automatic do_start(input int sz, input bit op);
        start  = 1'b1;
        size   = 3'(sz);
        two_op = op;
        tick();
        start  = 1'b0;
        exp_a  = '0;
        exp_b  = '0;
        chk("start_busy", TFW'(busy), TFW'(1));
        chk("start_ready", TFW'(in_ready), TFW'(1));
        chk("start_err", TFW'(err), '0);
    endtask

    // mode 0: back-to-back, 1: valid toggles every other cycle, 2: random gaps
    task automatic send_op(input int sz, input bit is_b, input int mode, input bit rnd);
        for (int r = 0; r < sz; r++) begin
            for (int c = 0; c < sz; c++) begin
                int gap;
                gap = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = TEW'($urandom_range(0, 255));
                    tick();
                end
                in_data  = rnd ? TEW'($urandom_range(0, 255)) : TEW'(next_val);
                next_val = next_val + val_step;
                in_valid = 1'b1;
                chk("load_ready", TFW'(in_ready), TFW'(1));
                if (r == sz - 1 && c == sz - 1)
                    chk("valid_early", TFW'(mats_valid), '0);
                if (is_b) exp_b[(r * TDIM + c) * TEW +: TEW] = in_data;
                else      exp_a[(r * TDIM + c) * TEW +: TEW] = in_data;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic load(input int sz, input bit op, input int mode, input bit rnd);
        do_start(sz, op);
        send_op(sz, 1'b0, mode, rnd);
        if (op) send_op(sz, 1'b1, mode, rnd);
        chk("done_valid", TFW'(mats_valid), TFW'(1));
        chk("done_ready", TFW'(in_ready), '0);
        chk("done_busy", TFW'(busy), TFW'(1));
        chk("done_A", A_flat, exp_a);
        chk("done_B", B_flat, exp_b);
    endtask

    task automatic ack();
        mats_ack = 1'b1;
        tick();
        mats_ack = 1'b0;
        chk("ack_valid", TFW'(mats_valid), '0);
        chk("ack_busy", TFW'(busy), '0);
        chk("ack_A_kept", A_flat, exp_a);
        chk("ack_B_kept", B_flat, exp_b);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int sz_bad [4] = '{1, 6, 0, 7};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // size 3, A only, beats 1..9
        next_val = 1;
        val_step = 1;
        load(3, 1'b0, 0, 1'b0);
        ack();

        // size 5, two operands, valid toggling, beats 0x00..0x31
        next_val = 0;
        load(5, 1'b1, 1, 1'b0);
        ack();

        // Illegal sizes: one-cycle err, nothing else moves
        foreach (sz_bad[i]) begin
            start = 1'b1;
            size  = 3'(sz_bad[i]);
            tick();
            start = 1'b0;
            chk("bad_err_pulse", TFW'(err), TFW'(1));
            chk("bad_busy", TFW'(busy), '0);
            tick();
            chk("bad_err_clear", TFW'(err), '0);
            chk("bad_busy2", TFW'(busy), '0);
            chk("bad_A_kept", A_flat, exp_a);
            chk("bad_B_kept", B_flat, exp_b);
        end

        // Reset mid-load discards partial data
        do_start(4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = TEW'($urandom_range(0, 255));
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        exp_a    = '0;
        exp_b    = '0;
        chk_all_zero("midreset");

        // Fresh size-2 load: 0xAA, 0xBB, 0xCC, 0xDD
        next_val = 'hAA;
        val_step = 'h11;
        load(2, 1'b0, 0, 1'b0);
        val_step = 1;

        // Hold in DONE with in_valid and start asserted
        in_valid = 1'b1;
        start    = 1'b1;
        size     = 3'd3;
        for (int k = 0; k < 10; k++) begin
            in_data = TEW'($urandom_range(0, 255));
            tick();
            chk("hold_valid", TFW'(mats_valid), TFW'(1));
            chk("hold_ready", TFW'(in_ready), '0);
        end
        chk("hold_A", A_flat, exp_a);
        chk("hold_B", B_flat, exp_b);
        mats_ack = 1'b1;
        tick();
        mats_ack = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("ackstart_valid", TFW'(mats_valid), '0);
        chk("ackstart_busy", TFW'(busy), '0);
        chk("ackstart_ready", TFW'(in_ready), '0);
        tick();
        chk("ackstart_idle", TFW'(busy), '0);
        chk("ackstart_A", A_flat, exp_a);

        // Randomized loads with random gaps and ack delays
        for (int it = 0; it < 8; it++) begin
            int sz;
            int dly;
            bit op;
            sz  = int'($urandom_range(2, 5));
            op  = 1'($urandom_range(0, 1));
            dly = int'($urandom_range(0, 3));
            load(sz, op, 2, 1'b1);
            for (int k = 0; k < dly; k++) begin
                tick();
                chk("rnd_hold_valid", TFW'(mats_valid), TFW'(1));
            end
            ack();
        end

        // mats_ack in IDLE is ignored
        mats_ack = 1'b1;
        tick();
        mats_ack = 1'b0;
        chk("idle_ack_busy", TFW'(busy), '0);
        chk("idle_ack_A", A_flat, exp_a);

`ifdef MATRIX_LOADER_TIMEOUT_EN
        begin : timeout_test
            int cycles;
            do_start(3, 1'b0);
            for (int k = 0; k < 2; k++) begin
                in_valid = 1'b1;
                in_data  = TEW'($urandom_range(1, 255));
                tick();
            end
            in_valid = 1'b0;
            cycles   = 0;
            while (!err && cycles < 40) begin
                tick();
                cycles++;
            end
            chk("to_cycles", TFW'(cycles), TFW'(16));
            chk("to_A", A_flat, '0);
            chk("to_B", B_flat, '0);
            chk("to_busy", TFW'(busy), '0);
            chk("to_ready", TFW'(in_ready), '0);
            tick();
            chk("to_err_clear", TFW'(err), '0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
